cmd_arbiter: RTL

Shares the single 4-bit security-FSM command input between NREQ requesters: panic button (req 0), WIFI link (req 1), keypad (req 2, …). It validates each command, grants one at a time, and holds the command for a fixed window followed by an idle gap, so the FSM samples every command as a distinct event. It also locks out requesters that repeatedly send invalid codes. It sits between the requester front-ends and the FSM command input.

---
 rtl/sec_cmd_pkg.sv | 13 +
 rtl/req_lockout.sv | 35 +++
 rtl/cmd_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/sec_cmd_pkg.sv
// sec_cmd_pkg: security FSM command codes, arbiter state encoding and code validation.
package sec_cmd_pkg;
  localparam logic [3:0] CMD_IDLE     = 4'b0000;
  localparam logic [3:0] CMD_DISARM   = 4'b1010;
  localparam logic [3:0] CMD_REARM    = 4'b1011;
  localparam logic [3:0] CMD_ESCALATE = 4'b1100;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  function automatic logic is_valid_cmd(input logic [3:0] c);
    return c == CMD_DISARM || c == CMD_REARM || c == CMD_ESCALATE;
  endfunction
endpackage

// File: rtl/req_lockout.sv
// req_lockout: per-requester consecutive-invalid counter and timed lockout.
module req_lockout #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic nack_i,
  input  logic ack_i,
  output logic locked_o
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [FW-1:0] fail;
  logic [TW-1:0] timer;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fail <= '0;
      timer <= '0;
      locked_o <= 1'b0;
    end else begin
      if (locked_o) begin
        if (timer == '0) locked_o <= 1'b0;
        else timer <= timer - 1'b1;
      end
      if (ack_i) fail <= '0;
      else if (nack_i) begin
        if (fail >= FW'(MAX_FAIL - 1)) begin
          fail <= '0;
          locked_o <= 1'b1;
          timer <= TW'(LOCK_CYCLES - 1);
        end else fail <= fail + 1'b1;
      end
    end
endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: validates, arbitrates and paces requester commands onto the single FSM command input.
module cmd_arbiter
  import sec_cmd_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] cmd_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   nack,
  output logic [3:0]        cmd_out,
  output logic              cmd_valid,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic [NREQ-1:0]   locked
);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] rr_ptr, win;
  logic [NREQ-1:0] elig, sh;
  logic [3:0] win_cmd;
  always_comb begin
    elig = req & ~locked;
    win = '0;
    sh = '0;
    // descending scan so the requester closest after rr_ptr is assigned last and wins
    for (int k = NREQ - 1; k >= 1; k--) begin
      sh = elig >> ((int'(rr_ptr) + k - 1) % (NREQ - 1) + 1);
      if (sh[0]) win = 3'((int'(rr_ptr) + k - 1) % (NREQ - 1) + 1);
    end
    if (elig[0]) win = '0;
    win_cmd = CMD_IDLE;
    for (int i = 0; i < NREQ; i++)
      if (win == 3'(i)) win_cmd = cmd_in[4*i +: 4];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      ack <= '0;
      nack <= '0;
      cmd_out <= CMD_IDLE;
      cmd_valid <= 1'b0;
      grant_id <= '0;
      busy <= 1'b0;
    end else begin
      ack <= '0;
      nack <= '0;
      if (state == ST_IDLE && |elig) begin
        busy <= 1'b1;
        if (win != '0) rr_ptr <= win;
        if (is_valid_cmd(win_cmd)) begin
          ack <= NREQ'(1) << win;
          cmd_out <= win_cmd;
          cmd_valid <= 1'b1;
          grant_id <= win;
          state <= ST_HOLD;
          cnt <= CW'(HOLD_CYCLES - 1);
        end else begin
          nack <= NREQ'(1) << win;
          state <= ST_GAP;
          cnt <= CW'(GAP_CYCLES - 1);
        end
      end else if (state == ST_HOLD) begin
        if (cnt == '0) begin
          cmd_out <= CMD_IDLE;
          cmd_valid <= 1'b0;
          state <= ST_GAP;
          cnt <= CW'(GAP_CYCLES - 1);
        end else cnt <= cnt - 1'b1;
      end else if (state == ST_GAP) begin
        if (cnt == '0) begin
          busy <= 1'b0;
          state <= ST_IDLE;
        end else cnt <= cnt - 1'b1;
      end
    end
  assign locked[0] = 1'b0;
  for (genvar g = 1; g < NREQ; g++) begin : g_lock
    req_lockout #(.MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) u_lock (
      .clk(clk),
      .reset(reset),
      .nack_i(nack[g]),
      .ack_i(ack[g]),
      .locked_o(locked[g])
    );
  end
endmodule
